// File: rtl/data_mem_ctrl.sv
// Byte-wide data RAM with a CPU port and a host load/dump engine.
// The CPU port is live only in IDLE; the engine stalls the CPU while it runs.
module data_mem_ctrl #(
  parameter int A     = 32,
  parameter int L     = 8,
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [A-1:0]  cpu_address_i,
  input  logic [31:0]   cpu_data_i,
  input  logic          cpu_WE_i,
  output logic [31:0]   cpu_data_o,
  output logic          cpu_stall_o,
  output logic          addr_err_o,
  input  logic [1:0]    host_mode_i,
  input  logic          host_start_i,
  input  logic [AW-1:0] host_base_i,
  input  logic [AW:0]   host_len_i,
  input  logic [L-1:0]  host_data_i,
  input  logic          host_valid_i,
  output logic          host_ready_o,
  output logic [L-1:0]  host_data_o,
  output logic          host_valid_o,
  input  logic          host_ready_i,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_DRD  = 3'd2;
  localparam logic [2:0] S_DOUT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [L-1:0]  cpu_q;
  logic [L-1:0]  hdata_q;
  logic          hvalid_q;
  logic          err_q;

  logic [L-1:0]  mem_q [DEPTH];

  logic          idle;
  logic          cpu_oor;
  logic          start_ok;
  logic          cnt_last;
  logic [AW:0]   cnt_inc;
  logic [AW:0]   sum;
  logic [AW-1:0] host_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [L-1:0]  mem_wdata;
  logic [L-1:0]  rd_data;
  logic          ld_fire;
  logic          out_fire;
  logic          unused_cpu_hi;

  assign unused_cpu_hi = ^cpu_data_i[31:L];

  assign idle      = (state_q == S_IDLE);
  assign cpu_oor   = (cpu_address_i >= A'(DEPTH));
  assign start_ok  = host_start_i &
                     ((host_mode_i == 2'b01) |
                      (host_mode_i == 2'b10));
  assign cnt_last  = (cnt_q == len_q);
  assign cnt_inc   = cnt_q + 1'b1;
  // base+cnt in AW+1 bits; dropping the MSB wraps modulo DEPTH
  assign sum       = {1'b0, base_q} + cnt_q;
  assign host_addr = sum[AW-1:0];

  assign host_ready_o = (state_q == S_LOAD) & ~cnt_last;
  assign ld_fire      = host_ready_o & host_valid_i;
  assign out_fire     = (state_q == S_DOUT) & hvalid_q & host_ready_i;

  assign mem_addr  = idle ? cpu_address_i[AW-1:0] : host_addr;
  assign mem_wdata = idle ? cpu_data_i[L-1:0] : host_data_i;
  assign mem_we    = RST & (idle ? (cpu_WE_i & ~cpu_oor) : ld_fire);
  assign rd_data   = mem_q[mem_addr];

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          base_d  = host_base_i;
          len_d   = host_len_i;
          cnt_d   = '0;
          state_d = (host_mode_i == 2'b01) ? S_LOAD : S_DRD;
        end
      end
      S_LOAD: begin
        if (cnt_last) state_d = S_DONE;
        else if (ld_fire) cnt_d = cnt_inc;
      end
      S_DRD: begin
        state_d = cnt_last ? S_DONE : S_DOUT;
      end
      S_DOUT: begin
        if (out_fire) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? S_DONE : S_DRD;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      cpu_q    <= '0;
      hdata_q  <= '0;
      hvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      if (idle) begin
        cpu_q <= cpu_oor ? '0 : rd_data;
        if (cpu_oor) err_q <= 1'b1;
      end
      if ((state_q == S_DRD) && !cnt_last) begin
        hdata_q  <= rd_data;
        hvalid_q <= 1'b1;
      end else if (out_fire) begin
        hvalid_q <= 1'b0;
      end
    end
  end

  assign cpu_data_o   = {{(32-L){1'b0}}, cpu_q};
  assign cpu_stall_o  = ~idle;
  assign busy_o       = ~idle;
  assign done_o       = (state_q == S_DONE);
  assign addr_err_o   = err_q;
  assign host_data_o  = hdata_q;
  assign host_valid_o = hvalid_q;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Byte-wide data memory controller that sits directly downstream of the CPU's data-memory port: it consumes `data_mem_address_o`, `data_mem_in_data_o` and `data_mem_WE_o`, and produces `data_mem_out_data_i`. It also provides a host-side load/dump engine. The engine preloads vector/scalar operands before a run and streams results out afterwards for comparison against golden files. While the engine runs, CPU accesses are blocked and `cpu_stall_o` is raised.

## Interface
Parameters:
- `A`, 32, CPU address width
- `L`, 8, memory word (byte) width
- `DEPTH`, 4096, number of L-bit locations; power of two
- `AW`, 12, log2(DEPTH); width of the host base address

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge
- `RST`  in  1  reset, synchronous, active-low
- `cpu_address_i`  in  A  CPU byte address
- `cpu_data_i`  in  32  CPU write data; bits [L-1:0] are used, the rest are ignored
- `cpu_WE_i`  in  1  CPU write enable
- `cpu_data_o`  out  32  registered read data, formatted {24'b0, byte}
- `cpu_stall_o`  out  1  high while the host engine owns the memory
- `addr_err_o`  out  1  sticky flag: a CPU access used an address ≥ DEPTH
- `host_mode_i`  in  2  01 = load, 10 = dump; 00 and 11 are ignored
- `host_start_i`  in  1  one-cycle start pulse; sampled only in IDLE
- `host_base_i`  in  AW  first memory location for the transfer
- `host_len_i`  in  AW+1  transfer length in bytes, 0..DEPTH
- `host_data_i`, `host_valid_i`, `host_ready_o`  load stream (host → memory): L / 1 / 1 bits
- `host_data_o`, `host_valid_o`, `host_ready_i`  dump stream (memory → host): L / 1 / 1 bits
- `busy_o`  out  1  high while the engine is outside IDLE
- `done_o`  out  1  one-cycle pulse when a transfer completes

## Operation
- **Memory:** DEPTH × L synchronous single-port RAM with a registered read. Contents are not cleared by reset.
- **CPU port (IDLE only):**
  - Write when `cpu_WE_i` = 1 and address < DEPTH.
  - Read every cycle: `cpu_data_o[7:0]` = mem[address] one cycle later.
  - Address ≥ DEPTH: write dropped, read returns 0, `addr_err_o` set. Only reset clears `addr_err_o`.
- **FSM states:** IDLE, LOAD, DUMP_RD, DUMP_OUT, DONE.
- **IDLE:**
  - On `host_start_i` with mode 01: latch base and len, clear `cnt`, go to LOAD.
  - On `host_start_i` with mode 10: same latching, go to DUMP_RD.
  - If the latched len = 0: go straight to DONE.
- **LOAD:**
  - `host_ready_o` = 1.
  - On each `host_valid_i` & `host_ready_o`: write `host_data_i` to mem[(base+cnt) mod DEPTH], `cnt`++.
  - When `cnt` reaches len: go to DONE.
- **DUMP_RD:** issue a read of mem[(base+cnt) mod DEPTH], then go to DUMP_OUT.
- **DUMP_OUT:**
  - `host_valid_o` = 1 with the read byte; data stays stable until `host_ready_i`.
  - On handshake: `cnt`++. If `cnt` reaches len, go to DONE; otherwise go to DUMP_RD.
- **DONE:** `done_o` = 1 for one cycle, then go to IDLE.
- **Addressing:** base+cnt is computed in AW+1 bits and truncated to AW, so addresses wrap modulo DEPTH.
- **CPU access while busy:** `cpu_WE_i` is ignored and `cpu_data_o` holds its last value. The CPU must hold its request until `cpu_stall_o` falls.
- **Conflicts:**
  - `host_start_i` outside IDLE is ignored.
  - Mode 00 or 11 at start is ignored; the FSM stays in IDLE.
  - A start in the same cycle as a CPU write: the CPU write commits first, and `cpu_stall_o` rises in the next cycle.
- **Reset mid-transfer:** the FSM returns to IDLE and the partial transfer is abandoned. Locations already written keep their values.

## Timing
- **Reset values:**
  - `cpu_data_o` = 0, `cpu_stall_o` = 0, `addr_err_o` = 0.
  - `host_ready_o` = 0, `host_valid_o` = 0, `host_data_o` = 0.
  - `busy_o` = 0, `done_o` = 0, FSM = IDLE.
- CPU read latency: 1 cycle. CPU writes are visible to a read issued in the next cycle.
- `busy_o` and `cpu_stall_o` rise the cycle after the start pulse and fall the cycle after DONE.
- Load throughput: 1 byte/cycle with continuous `host_valid_i`. A load of N bytes, from start to the `done_o` pulse, takes N+2 cycles.
- Dump throughput: 1 byte per 2 cycles with `host_ready_i` held high. The first `host_valid_o` appears 2 cycles after start.
- `host_data_o` and `host_valid_o` are registered outputs. `host_ready_o` is decoded from the FSM state.

## Test plan
- **Reset and CPU access:**
  - Stimulus: `RST` = 0 for 2 cycles, then CPU writes 0xA5 to address 10 and reads address 10.
  - Required: `cpu_data_o` = 0x000000A5 one cycle after the read; all other outputs at their reset values during reset.
- **Load:**
  - Stimulus: mode 01, base 4, len 3, bytes 11/22/33 with `host_valid_i` toggling.
  - Required: exactly 3 writes; CPU reads of addresses 4..6 return 11, 22, 33; `done_o` pulses once.
- **Dump with back-pressure:**
  - Stimulus: dump base 4, len 3, with `host_ready_i` low for 3 cycles on the second byte.
  - Required: `host_data_o` holds 22 stable until the handshake; output sequence is 11, 22, 33.
- **Wrap and zero length:**
  - Stimulus: load base 4094, len 4; then a dump with len 0.
  - Required: the load writes addresses 4094, 4095, 0, 1; the dump produces `done_o` two cycles after start with no `host_valid_o`.
- **Out-of-range and stall:**
  - Stimulus: CPU write to 5000; then a CPU write issued during a load.
  - Required: `addr_err_o` = 1 and stays high; the write issued during the load is dropped.
- **Mid-op reset:**
  - Stimulus: assert `RST` = 0 after 2 of 5 load bytes.
  - Required: the FSM returns to IDLE; the 2 bytes already loaded are retained; no `done_o` pulse.
